// File: rtl/ieee_pkg.sv
// Shared IEEE-754 single-precision constants, FSM state type and a field packer
// for the multiplier arbiter slice.
package ieee_pkg;

    localparam int FP_W     = 32;
    localparam int SIGN_W   = 1;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int EXP_BIAS = 127;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [FP_W-1:0] fp_pack(
        input logic [SIGN_W-1:0] sign,
        input logic [EXP_W-1:0]  expo,
        input logic [MAN_W-1:0]  man
    );
        return {sign, expo, man};
    endfunction

endpackage

// File: rtl/ieee_mul.sv
// Combinational IEEE-754 single-precision multiplier: round-to-nearest-even,
// subnormal inputs and results flushed to signed zero, quiet NaN on invalid.
module ieee_mul
    import ieee_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic [FP_W-1:0] p
);

    localparam logic [FP_W-1:0] QNAN = 32'h7FC0_0000;

    logic                 sign_s;
    logic [EXP_W-1:0]     ea_s;
    logic [EXP_W-1:0]     eb_s;
    logic [MAN_W-1:0]     ma_s;
    logic [MAN_W-1:0]     mb_s;
    logic                 a_zero_s;
    logic                 b_zero_s;
    logic                 a_inf_s;
    logic                 b_inf_s;
    logic                 a_nan_s;
    logic                 b_nan_s;
    logic [47:0]          prod_s;
    logic                 norm_s;
    logic [MAN_W-1:0]     man_s;
    logic                 guard_s;
    logic                 sticky_s;
    logic [MAN_W:0]       man_rnd_s;
    logic [10:0]          exp_s;

    // Field decode, significand product, rounding and special-case selection
    always_comb begin
        sign_s   = a[FP_W-1] ^ b[FP_W-1];
        ea_s     = a[FP_W-2 -: EXP_W];
        eb_s     = b[FP_W-2 -: EXP_W];
        ma_s     = a[MAN_W-1:0];
        mb_s     = b[MAN_W-1:0];
        a_zero_s = (ea_s == 8'h00);
        b_zero_s = (eb_s == 8'h00);
        a_inf_s  = (ea_s == 8'hFF) && (ma_s == 23'd0);
        b_inf_s  = (eb_s == 8'hFF) && (mb_s == 23'd0);
        a_nan_s  = (ea_s == 8'hFF) && (ma_s != 23'd0);
        b_nan_s  = (eb_s == 8'hFF) && (mb_s != 23'd0);

        prod_s = 48'({1'b1, ma_s}) * 48'({1'b1, mb_s});
        norm_s = prod_s[47];
        // Product lies in [1,4): a set top bit means one extra exponent step
        if (norm_s) begin
            man_s    = prod_s[46:24];
            guard_s  = prod_s[23];
            sticky_s = |prod_s[22:0];
        end else begin
            man_s    = prod_s[45:23];
            guard_s  = prod_s[22];
            sticky_s = |prod_s[21:0];
        end
        man_rnd_s = {1'b0, man_s} + {{MAN_W{1'b0}}, guard_s & (sticky_s | man_s[0])};
        exp_s     = {3'b000, ea_s} + {3'b000, eb_s} + {10'd0, norm_s}
                  + {10'd0, man_rnd_s[MAN_W]} - 11'(EXP_BIAS);

        if (a_nan_s || b_nan_s || (a_inf_s && b_zero_s) || (b_inf_s && a_zero_s)) begin
            p = QNAN;
        end else if (a_inf_s || b_inf_s) begin
            p = fp_pack(sign_s, 8'hFF, 23'd0);
        end else if (a_zero_s || b_zero_s) begin
            p = fp_pack(sign_s, 8'h00, 23'd0);
        end else if (exp_s[10] || (exp_s == 11'd0)) begin
            p = fp_pack(sign_s, 8'h00, 23'd0);
        end else if (exp_s >= 11'd255) begin
            p = fp_pack(sign_s, 8'hFF, 23'd0);
        end else begin
            p = fp_pack(sign_s, exp_s[7:0], man_rnd_s[MAN_W-1:0]);
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: first set request at or above ptr, wrapping modulo NREQ.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt
);

    localparam int IDW = $clog2(NREQ);
    localparam logic [IDW:0] NREQ_V = NREQ[IDW:0];

    logic [IDW:0]   sum_s;
    logic [IDW-1:0] idx_s;
    logic           found_s;

    // Scan from ptr upward; the extra sum bit keeps the wrap subtraction exact
    always_comb begin
        gnt     = '0;
        found_s = 1'b0;
        sum_s   = '0;
        idx_s   = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum_s = {1'b0, ptr} + (IDW+1)'(k);
            if (sum_s >= NREQ_V) begin
                sum_s = sum_s - NREQ_V;
            end else begin
                sum_s = sum_s;
            end
            idx_s = sum_s[IDW-1:0];
            if (!found_s && req[idx_s]) begin
                gnt[idx_s] = 1'b1;
                found_s    = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/ieee_mul_arbiter.sv
// Shares one combinational IEEE-754 multiplier among NREQ requesters with a
// round-robin IDLE -> MUL -> RESP pipeline, one operation in flight at a time.
module ieee_mul_arbiter #(
    parameter int NREQ = 4,
    parameter int FP_W = ieee_pkg::FP_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*FP_W-1:0]     req_a,
    input  logic [NREQ*FP_W-1:0]     req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [FP_W-1:0]          rsp_data,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic                     busy
);

    import ieee_pkg::state_t;
    import ieee_pkg::IDLE;
    import ieee_pkg::MUL;
    import ieee_pkg::RESP;

    localparam int IDW = $clog2(NREQ);
    localparam logic [IDW:0] NREQ_V = NREQ[IDW:0];

    state_t          state_r;
    logic [IDW-1:0]  rr_ptr_r;
    logic [FP_W-1:0] op_a_r;
    logic [FP_W-1:0] op_b_r;
    logic [NREQ-1:0] gnt_s;
    logic [IDW-1:0]  gnt_idx_s;
    logic [FP_W-1:0] sel_a_s;
    logic [FP_W-1:0] sel_b_s;
    logic [FP_W-1:0] mul_out_s;
    logic [IDW:0]    ptr_inc_s;
    logic [IDW-1:0]  ptr_next_s;

    rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
        .req (req_valid),
        .ptr (rr_ptr_r),
        .gnt (gnt_s)
    );

    ieee_mul u_ieee_mul (
        .a (op_a_r),
        .b (op_b_r),
        .p (mul_out_s)
    );

    // Grant is only exposed in IDLE and out of reset
    always_comb begin
        if ((state_r == IDLE) && !rst) begin
            req_ready = gnt_s;
        end else begin
            req_ready = '0;
        end
    end

    // One-hot grant to winner index and its operand slices
    always_comb begin
        gnt_idx_s = '0;
        sel_a_s   = '0;
        sel_b_s   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_s[i]) begin
                gnt_idx_s = IDW'(i);
                sel_a_s   = req_a[i*FP_W +: FP_W];
                sel_b_s   = req_b[i*FP_W +: FP_W];
            end else begin
                gnt_idx_s = gnt_idx_s;
            end
        end
    end

    // Pointer after a completed response: owner + 1, wrapping to 0
    always_comb begin
        ptr_inc_s = {1'b0, rsp_id} + {{IDW{1'b0}}, 1'b1};
        if (ptr_inc_s == NREQ_V) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = ptr_inc_s[IDW-1:0];
        end
    end

    // Operation FSM with registered response, owner id and busy flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            rr_ptr_r  <= '0;
            op_a_r    <= '0;
            op_b_r    <= '0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (|gnt_s) begin
                        op_a_r  <= sel_a_s;
                        op_b_r  <= sel_b_s;
                        rsp_id  <= gnt_idx_s;
                        busy    <= 1'b1;
                        state_r <= MUL;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                MUL: begin
                    rsp_data  <= mul_out_s;
                    rsp_valid <= 1'b1;
                    state_r   <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        rr_ptr_r  <= ptr_next_s;
                        state_r   <= IDLE;
                    end else begin
                        state_r <= RESP;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ieee_mul_arbiter.sv
// Scoreboard bench for ieee_mul_arbiter: expected products are pushed at grant
// time from an independent real-arithmetic model and popped on each response.
module tb_ieee_mul_arbiter;

    localparam int NREQ = 4;
    localparam int FP_W = 32;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*FP_W-1:0] req_a;
    logic [NREQ*FP_W-1:0] req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [FP_W-1:0]      rsp_data;
    logic [IDW-1:0]       rsp_id;
    logic                 busy;

    typedef struct packed {
        logic [IDW-1:0]  id;
        logic [FP_W-1:0] data;
    } exp_t;

    exp_t        sb_q[$];
    int          gnt_log[$];
    int          gnt_cyc[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          first_rsp_cyc;
    logic        hold_mode;
    logic [31:0] last_by_id [NREQ];
    logic [NREQ-1:0] granted;

    ieee_mul_arbiter #(.NREQ(NREQ), .FP_W(FP_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Requesters keep valid and operands steady until accepted
    for (genvar g = 0; g < NREQ; g++) begin : g_hold
        a_hold: assert property (@(posedge clk) disable iff (rst)
            (req_valid[g] && !req_ready[g]) |=>
            (req_valid[g] && $stable(req_a[g*FP_W +: FP_W]) && $stable(req_b[g*FP_W +: FP_W])));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Exact double product of two floats, rounded to nearest-even single
    function automatic logic [31:0] fp_mul_model(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] da, db, dp;
        logic [52:0] m;
        logic [23:0] top;
        logic [24:0] rnd;
        logic        guard, sticky;
        int          e;
        real         r;
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {a[31] ^ b[31], 31'd0};
        da = {a[31], 11'(a[30:23]) + 11'd896, a[22:0], 29'd0};
        db = {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0};
        r  = $bitstoreal(da) * $bitstoreal(db);
        dp = $realtobits(r);
        e  = int'(dp[62:52]) - 896;
        m  = {1'b1, dp[51:0]};
        top    = m[52:29];
        guard  = m[28];
        sticky = |m[27:0];
        rnd = {1'b0, top} + ((guard && (sticky || top[0])) ? 25'd1 : 25'd0);
        if (rnd[24]) begin
            rnd = rnd >> 1;
            e++;
        end
        return {dp[63], 8'(e), rnd[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp();
        return {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
    endfunction

    function automatic logic [31:0] slice(input logic [NREQ*FP_W-1:0] v, input int i);
        logic [NREQ*FP_W-1:0] t;
        t = v >> (i * FP_W);
        return t[31:0];
    endfunction

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        logic [NREQ*FP_W-1:0] mask;
        mask  = {{(NREQ-1)*FP_W{1'b0}}, {FP_W{1'b1}}} << (i * FP_W);
        req_a = (req_a & ~mask) | ({{(NREQ-1)*FP_W{1'b0}}, a} << (i * FP_W));
        req_b = (req_b & ~mask) | ({{(NREQ-1)*FP_W{1'b0}}, b} << (i * FP_W));
    endtask

    // One clock: monitor at negedge, then requester reaction just after posedge
    task automatic step();
        exp_t e;
        @(negedge clk);
        granted = '0;
        if (!rst) begin
            if (req_ready != '0) begin
                check("ready_onehot", 32'($countones(req_ready)), 32'd1);
                for (int i = 0; i < NREQ; i++) begin
                    if (req_ready[i]) begin
                        granted[i] = 1'b1;
                        gnt_log.push_back(i);
                        gnt_cyc.push_back(cyc);
                        e.id   = IDW'(i);
                        e.data = fp_mul_model(slice(req_a, i), slice(req_b, i));
                        sb_q.push_back(e);
                    end
                end
            end
            if (busy) check("ready_in_flight", 32'(req_ready), 32'd0);
            if (rsp_valid && first_rsp_cyc < 0) first_rsp_cyc = cyc;
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_empty", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_id", 32'(rsp_id), 32'(e.id));
                    last_by_id[rsp_id] = rsp_data;
                end
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (granted[i]) begin
                if (hold_mode) set_op(i, rand_fp(), rand_fp());
                else req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic wait_grants(input int n, input int budget);
        int k = 0;
        while (gnt_log.size() < n && k < budget) begin
            step();
            k++;
        end
        if (gnt_log.size() < n) check("grant_timeout", 32'(gnt_log.size()), 32'(n));
    endtask

    task automatic drain();
        int k = 0;
        while ((req_valid != '0 || busy || sb_q.size() != 0) && k < 100) begin
            step();
            k++;
        end
        check("drain_done", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        req_valid = '0;
        hold_mode = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        gnt_log.delete();
        gnt_cyc.delete();
        first_rsp_cyc = -1;
    endtask

    initial begin
        logic [31:0] d_hold;
        logic [31:0] id_hold;
        int          k;
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
        rsp_ready = 1'b1; hold_mode = 1'b0; first_rsp_cyc = -1;
        for (int i = 0; i < NREQ; i++) set_op(i, rand_fp(), rand_fp());

        // Reset values, with every requester asking during reset
        repeat (2) @(posedge clk);
        #1 req_valid = '1;
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        req_valid = '0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Single request 2.0 * 3.0 with latency check
        set_op(0, 32'h4000_0000, 32'h4040_0000);
        req_valid = 4'b0001;
        wait_grants(1, 20);
        drain();
        check("t1_gnt", 32'(gnt_log[0]), 32'd0);
        check("t1_latency", 32'(first_rsp_cyc - gnt_cyc[0]), 32'd2);
        check("t1_six", last_by_id[0], 32'h40C0_0000);

        // Back-pressure in RESP: outputs frozen, nothing accepted
        gnt_log.delete(); gnt_cyc.delete();
        rsp_ready = 1'b0;
        set_op(2, rand_fp(), rand_fp());
        req_valid = 4'b0100;
        k = 0;
        while (!rsp_valid && k < 20) begin
            step();
            #1;
            k++;
        end
        check("t2_rsp_seen", 32'(rsp_valid), 32'd1);
        d_hold  = rsp_data;
        id_hold = 32'(rsp_id);
        check("t2_id", id_hold, 32'd2);
        set_op(0, rand_fp(), rand_fp());
        set_op(1, rand_fp(), rand_fp());
        set_op(3, rand_fp(), rand_fp());
        req_valid = 4'b1011;
        for (int c = 0; c < 5; c++) begin
            step();
            #1;
            check("t2_valid_hold", 32'(rsp_valid), 32'd1);
            check("t2_data_hold", rsp_data, d_hold);
            check("t2_id_hold", 32'(rsp_id), id_hold);
            check("t2_ready_zero", 32'(req_ready), 32'd0);
            check("t2_busy", 32'(busy), 32'd1);
        end
        rsp_ready = 1'b1;
        drain();
        check("t2_order_n", 32'(gnt_log.size()), 32'd4);
        if (gnt_log.size() == 4) begin
            check("t2_order1", 32'(gnt_log[1]), 32'd3);
            check("t2_order2", 32'(gnt_log[2]), 32'd0);
            check("t2_order3", 32'(gnt_log[3]), 32'd1);
        end

        // All four held valid: 0,1,2,3,0 three cycles apart
        do_reset();
        hold_mode = 1'b1;
        req_valid = 4'b1111;
        wait_grants(5, 40);
        if (gnt_log.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                check("t3_order", 32'(gnt_log[i]), 32'(i % NREQ));
                if (i > 0) check("t3_spacing", 32'(gnt_cyc[i] - gnt_cyc[i-1]), 32'd3);
            end
        end

        // Requesters 1 and 3 only: 1,3,1,3
        do_reset();
        hold_mode = 1'b1;
        req_valid = 4'b1010;
        wait_grants(4, 40);
        if (gnt_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check("t4_order", 32'(gnt_log[i]), (i % 2 == 0) ? 32'd1 : 32'd3);
            end
        end

        // Reset in MUL discards the result and restarts search at 0
        do_reset();
        set_op(2, rand_fp(), rand_fp());
        req_valid = 4'b0100;
        drain();
        gnt_log.delete(); gnt_cyc.delete();
        set_op(0, rand_fp(), rand_fp());
        req_valid = 4'b0001;
        wait_grants(1, 20);
        check("t5_pre_gnt", 32'(gnt_log[0]), 32'd0);
        #1;
        check("t5_busy_mul", 32'(busy), 32'd1);
        rst = 1'b1;
        req_valid = '0;
        #1;
        check("t5_rst_valid", 32'(rsp_valid), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        sb_q.delete(); gnt_log.delete(); gnt_cyc.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        set_op(2, 32'h4780_0060, 32'h4142_0000);
        set_op(3, rand_fp(), rand_fp());
        req_valid = 4'b1100;
        drain();
        check("t5_order_n", 32'(gnt_log.size()), 32'd2);
        if (gnt_log.size() == 2) begin
            check("t5_first", 32'(gnt_log[0]), 32'd2);
            check("t5_second", 32'(gnt_log[1]), 32'd3);
        end
        check("t6_rne_product", last_by_id[2], 32'h4942_0092);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ieee_mul_arbiter.md
IEEE_MUL_ARBITER -- requirements
Module: ieee_mul_arbiter

Interface
REQ-001 Parameter NREQ, default 4, is the number of requesters sharing one multiplier; legal values are 2..8.
REQ-002 Parameter FP_W, default 32, is the IEEE-754 single-precision operand width.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port req_valid, input, NREQ bits: bit i set means requester i presents an operand pair.
REQ-006 Port req_ready, output, NREQ bits: one-hot or zero; bit i set means the pair from requester i is accepted this cycle.
REQ-007 Port req_a, input, NREQ*FP_W bits: multiplicands; slice i belongs to requester i.
REQ-008 Port req_b, input, NREQ*FP_W bits: multipliers; slice i belongs to requester i.
REQ-009 Port rsp_valid, output, 1 bit: a result is presented.
REQ-010 Port rsp_ready, input, 1 bit: the consumer accepts the result.
REQ-011 Port rsp_data, output, FP_W bits: the IEEE-754 product.
REQ-012 Port rsp_id, output, clog2(NREQ) bits: index of the requester that owns rsp_data.
REQ-013 Port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 The FSM SHALL have three states, entered in the order IDLE -> MUL -> RESP -> IDLE.
REQ-015 In IDLE with any req_valid bit set, the block SHALL grant the first set bit found searching upward from rr_ptr, wrapping modulo NREQ.
REQ-016 The grant SHALL assert req_ready for the winner in the same cycle, combinationally from req_valid, rr_ptr and state.
REQ-017 At that clock edge the block SHALL capture the winner's req_a and req_b slices into operand registers, capture the winner index into rsp_id, and go to MUL.
REQ-018 In MUL, the output of the combinational ieee_mul instance, fed from the operand registers, SHALL be registered into rsp_data, and the FSM SHALL go to RESP.
REQ-019 In RESP, rsp_valid SHALL be 1, and rsp_data and rsp_id SHALL be held stable until rsp_ready is 1.
REQ-020 On a cycle with rsp_valid=1 and rsp_ready=1, the FSM SHALL return to IDLE and set rr_ptr to (rsp_id+1) mod NREQ.
REQ-021 Latency: rsp_valid SHALL first be asserted two cycles after the accept cycle; peak throughput is one operation per three cycles.
REQ-022 req_ready SHALL be all-zero in MUL and RESP, so no request is accepted while an operation is in flight.
REQ-023 A new request SHALL NOT be accepted in the same cycle as a response handshake; acceptance happens no earlier than the following IDLE cycle.
REQ-024 A requester that drops req_valid before its grant SHALL simply not be granted, and no state SHALL change.
REQ-025 Requesters SHALL hold req_valid and operands stable until their req_ready; the bench checks this with an assertion.
REQ-026 Arithmetic: rsp_data SHALL equal the ieee_mul output for the captured operands bit-exactly; the arbiter SHALL NOT modify the sign, exponent or mantissa.
REQ-027 Wrap-around: rr_ptr = NREQ-1 followed by a grant to NREQ-1 SHALL give rr_ptr = 0.

Reset
REQ-028 While rst=1, asynchronously: state SHALL be IDLE, rr_ptr 0, operand registers 0, rsp_data 0, rsp_id 0, rsp_valid 0, busy 0, and req_ready all-zero.
REQ-029 Reset asserted mid-operation, in MUL or RESP, SHALL discard the in-flight result with no response produced.
REQ-030 After reset release, arbitration SHALL restart from requester 0.

Structure
REQ-031 Package ieee_pkg SHALL hold FP_W, the FSM state enum (IDLE, MUL, RESP) and the IEEE field-width constants (sign 1, exponent 8, mantissa 23).
REQ-032 The round-robin grant logic SHALL be a sub-module rr_arbiter with ports req, ptr and gnt (one-hot), parameterised by NREQ.
REQ-033 The existing combinational ieee_mul module SHALL be instantiated once, unchanged.

Verification
REQ-034 Only req_valid[0], a=0x40000000 (2.0), b=0x40400000 (3.0) -> req_ready[0] for one cycle, rsp_valid two cycles later, rsp_data=0x40C00000 (6.0), rsp_id=0.
REQ-035 All four requesters valid and held after reset, rsp_ready tied to 1 -> grants in order 0,1,2,3,0, each req_ready one cycle wide, three cycles apart.
REQ-036 Only requesters 1 and 3 continuously valid -> grant sequence 1,3,1,3; requester 3 wraps rr_ptr to 0.
REQ-037 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_id stable for those cycles, req_ready all-zero, busy=1.
REQ-038 rst pulsed for one cycle while in MUL -> rsp_valid and busy drop immediately; with requester 2 then valid after release, the grant goes to 2, searched from pointer 0.
REQ-039 Operands 0x47800060 (65536.75) and 0x41420000 (12.125) -> rsp_data equals the standalone ieee_mul output for the same operands bit-for-bit.
